mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle for mem_access_unit.
// Member names match the unit's CPU port names.
interface mem_access_unit_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store unit in front of a 32-bit lane-enabled RAM.
// Halfword stores become two byte writes, so the RAM only ever sees sel 0,1,2,4,8,15.
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST,
  mem_access_unit_if.slave  cpu,
  output logic [ADDR_W-1:0] addres,
  output logic [31:0]       Din,
  output logic              MemWrite,
  output logic [3:0]        sel,
  input  logic [31:0]       Dout
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [7:0]        whi_q, whi_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addres_q, addres_d;
  logic [31:0]       din_q, din_d;

  function automatic logic is_bad(input logic [1:0] sz, input logic [1:0] off);
    is_bad = (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (sz)
      2'd0:    load_extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    load_extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    whi_d    = whi_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    addres_d = addres_q;
    din_d    = din_q;
    MemWrite = 1'b0;
    sel      = 4'd0;
    case (state_q)
      IDLE: begin
        if (cpu.req_valid) begin
          we_d   = cpu.req_we;
          size_d = cpu.req_size;
          uns_d  = cpu.req_unsigned;
          off_d  = cpu.req_addr[1:0];
          whi_d  = cpu.req_wdata[15:8];
          if (is_bad(cpu.req_size, cpu.req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d    = 1'b0;
            state_d  = ACC0;
            addres_d = cpu.req_addr[ADDR_W+1:2];
            if (cpu.req_we)
              din_d = (cpu.req_size == 2'd2) ? cpu.req_wdata : {4{cpu.req_wdata[7:0]}};
          end
        end
      end
      ACC0: begin
        MemWrite = we_q;
        sel      = (!we_q || size_q == 2'd2) ? 4'hF : (4'b0001 << off_q);
        if (we_q && size_q == 2'd1) begin
          state_d = ACC1;
          din_d   = {4{whi_q}};
        end else begin
          state_d = RESP;
          if (!we_q) rdata_d = load_extract(Dout, size_q, off_q, uns_q);
        end
      end
      ACC1: begin
        MemWrite = 1'b1;
        sel      = 4'b0001 << (off_q + 2'd1);
        state_d  = RESP;
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle must never reach the RAM, e.g. the high byte of an aborted halfword.
    if (RST) begin
      MemWrite = 1'b0;
      sel      = 4'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      off_q    <= 2'd0;
      whi_q    <= 8'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      addres_q <= '0;
      din_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      off_q    <= off_d;
      whi_q    <= whi_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      addres_q <= addres_d;
      din_q    <= din_d;
    end
  end

  assign cpu.req_ready  = (state_q == IDLE);
  assign cpu.resp_valid = (state_q == RESP);
  assign cpu.resp_err   = (state_q == RESP) && err_q;
  assign cpu.resp_rdata = rdata_q;
  assign addres         = addres_q;
  assign Din            = din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// responses and RAM writes; negedge monitors pop and compare.
module tb_mem_access_unit;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addres;
  logic [31:0]       Din;
  logic              MemWrite;
  logic [3:0]        sel;
  logic [31:0]       Dout;
  logic [31:0]       mem [0:1023];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        sel;
    logic [31:0]       din;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];

  mem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST(rst), .cpu(bus.slave),
    .addres(addres), .Din(Din), .MemWrite(MemWrite), .sel(sel), .Dout(Dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign Dout = mem[addres];
  always @(posedge clk)
    if (MemWrite)
      for (int i = 0; i < 4; i++)
        if (sel[i]) mem[addres][8*i +: 8] <= Din[8*i +: 8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none pending");
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        check("resp_err", 32'(bus.resp_err), 32'(e.err));
        check("resp_rdata", bus.resp_rdata, e.rdata);
        check("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  // RAM write monitor
  always @(negedge clk) begin
    if (MemWrite === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got MemWrite=1 sel=%0d addres=%0d expected none", sel, addres);
      end else begin
        wr_t w;
        logic [31:0] m;
        w = wr_q.pop_front();
        m = {{8{w.sel[3]}}, {8{w.sel[2]}}, {8{w.sel[1]}}, {8{w.sel[0]}}};
        check("wr_sel", 32'(sel), 32'(w.sel));
        check("wr_addres", 32'(addres), 32'(w.addr));
        check("wr_din_lanes", Din & m, w.din & m);
      end
    end
  end

  task automatic expect_write(input int a, input logic [3:0] s, input logic [31:0] d);
    wr_t w;
    w.addr = ADDR_W'(a); w.sel = s; w.din = d;
    wr_q.push_back(w);
  endtask

  // lat = 0 means no response is expected
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [ADDR_W+1:0] addr, input logic [31:0] wdata,
                       input logic err, input logic [31:0] rdata, input int lat);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got req_ready=0 for 50 cycles expected 1");
    end
    bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    if (lat != 0) begin
      resp_t e;
      e.err = err; e.rdata = rdata; e.lat = lat; e.acc = cyc + 1;
      resp_q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = 32'hDEAD_BEEF;
    bus.req_we    = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_addres", 32'(addres), 32'd0);
    check("rst_din", Din, 32'd0);

    // word store then word load
    expect_write(4, 4'hF, 32'h1122_3344);
    issue(1, 2, 0, 12'h010, 32'h1122_3344, 0, 32'h0, 2);
    issue(0, 2, 0, 12'h010, 32'h0, 0, 32'h1122_3344, 2);
    // byte store at lane 3 then signed/unsigned byte loads
    expect_write(4, 4'h8, 32'hA500_0000);
    issue(1, 0, 0, 12'h013, 32'h0000_00A5, 0, 32'h1122_3344, 2);
    issue(0, 0, 0, 12'h013, 32'h0, 0, 32'hFFFF_FFA5, 2);
    issue(0, 0, 1, 12'h013, 32'h0, 0, 32'h0000_00A5, 2);
    // halfword store at offset 2: two byte writes
    expect_write(8, 4'h4, 32'h00EF_0000);
    expect_write(8, 4'h8, 32'hBE00_0000);
    issue(1, 1, 0, 12'h022, 32'h0000_BEEF, 0, 32'h0000_00A5, 3);
    issue(0, 1, 0, 12'h022, 32'h0, 0, 32'hFFFF_BEEF, 2);
    issue(0, 1, 1, 12'h022, 32'h0, 0, 32'h0000_BEEF, 2);
    // mem[4] is now 0xA5223344
    issue(0, 0, 1, 12'h011, 32'h0, 0, 32'h0000_0033, 2);
    issue(0, 1, 0, 12'h012, 32'h0, 0, 32'hFFFF_A522, 2);
    // misaligned / illegal: error, no RAM access, rdata held
    issue(0, 2, 0, 12'h006, 32'h0, 1, 32'hFFFF_A522, 1);
    issue(1, 1, 0, 12'h001, 32'h0000_7777, 1, 32'hFFFF_A522, 1);
    issue(1, 3, 0, 12'h000, 32'h1234_5678, 1, 32'hFFFF_A522, 1);

    // reset during ACC1 of a halfword store: only low byte lands
    expect_write(16, 4'h1, 32'h0000_0034);
    issue(1, 1, 0, 12'h040, 32'h0000_1234, 0, 32'h0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_resp_rdata", bus.resp_rdata, 32'd0);
    check("abort_mem_word", mem[16], 32'h0000_0034);
    issue(0, 2, 0, 12'h040, 32'h0, 0, 32'h0000_0034, 2);

    begin
      int n = 0;
      while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (resp_q.size() != 0 || wr_q.size() != 0) begin
        errors++;
        $display("FAIL drain: got %0d responses %0d writes pending expected 0", resp_q.size(), wr_q.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
